// File: rtl/ccip_host_mem_responder.sv
// Host-side CCI-P memory model: c0 reads go through an in-order queue to a line RAM,
// c1 writes update the RAM immediately and are acked through a two-stage pipe.
module ccip_host_mem_responder #(
  parameter int ADDR_W        = 42,
  parameter int LINE_W        = 512,
  parameter int MDATA_W       = 16,
  parameter int DEPTH_LOG2    = 6,
  parameter int FIFO_DEPTH    = 8,
  parameter int ALMFULL_SLACK = 4,
  parameter int RSP_GAP       = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               c0_req_valid,
  input  logic [ADDR_W-1:0]  c0_req_addr,
  input  logic [MDATA_W-1:0] c0_req_mdata,
  input  logic               c1_req_valid,
  input  logic [ADDR_W-1:0]  c1_req_addr,
  input  logic [MDATA_W-1:0] c1_req_mdata,
  input  logic [LINE_W-1:0]  c1_req_data,
  output logic               c0TxAlmFull,
  output logic               c1TxAlmFull,
  output logic               c0_rsp_valid,
  output logic [MDATA_W-1:0] c0_rsp_mdata,
  output logic [LINE_W-1:0]  c0_rsp_data,
  output logic               c1_rsp_valid,
  output logic [MDATA_W-1:0] c1_rsp_mdata,
  output logic               err_overflow,
  output logic               err_oob
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DEPTH_LOG2 + MDATA_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ALMOST = CNT_W'(FIFO_DEPTH - ALMFULL_SLACK);

  logic c0_oob;
  logic c1_oob;
  assign c0_oob = |c0_req_addr[ADDR_W-1:DEPTH_LOG2];
  assign c1_oob = |c1_req_addr[ADDR_W-1:DEPTH_LOG2];

  logic [LINE_W-1:0] line_mem [DEPTH];
  logic [ENT_W-1:0]  q_mem [FIFO_DEPTH];

  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [CNT_W-1:0]   count_next;
  logic [7:0]         gap_reg;
  logic               wr_valid_reg;
  logic [MDATA_W-1:0] wr_mdata_reg;

  logic                  pop;
  logic                  push;
  logic                  wr_ok;
  logic [ENT_W-1:0]      pop_ent;
  logic [DEPTH_LOG2-1:0] pop_line;
  logic [MDATA_W-1:0]    pop_mdata;
  logic                  pop_oob;

  assign pop   = (count_reg != '0) && (gap_reg == '0);
  // A pop frees a slot in the same cycle, so a push into a full queue survives it.
  assign push  = c0_req_valid && ((count_reg != CNT_FULL) || pop);
  assign wr_ok = c1_req_valid && !c1_oob;

  assign pop_ent = q_mem[rd_ptr_reg];
  assign {pop_line, pop_mdata, pop_oob} = pop_ent;

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (!push && pop) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && wr_ok) begin
      line_mem[c1_req_addr[DEPTH_LOG2-1:0]] <= c1_req_data;
    end
    if (reset_n && push) begin
      q_mem[wr_ptr_reg] <= {c0_req_addr[DEPTH_LOG2-1:0], c0_req_mdata, c0_oob};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      gap_reg      <= '0;
      c0TxAlmFull  <= 1'b1;
      c1TxAlmFull  <= 1'b1;
      c0_rsp_valid <= 1'b0;
      c0_rsp_mdata <= '0;
      c0_rsp_data  <= '0;
      wr_valid_reg <= 1'b0;
      wr_mdata_reg <= '0;
      c1_rsp_valid <= 1'b0;
      c1_rsp_mdata <= '0;
      err_overflow <= 1'b0;
      err_oob      <= 1'b0;
    end else begin
      count_reg   <= count_next;
      c0TxAlmFull <= (count_next >= CNT_ALMOST);
      c1TxAlmFull <= 1'b0;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        gap_reg    <= 8'(RSP_GAP);
      end else if (gap_reg != '0) begin
        gap_reg <= gap_reg - 1'b1;
      end
      c0_rsp_valid <= pop;
      if (pop) begin
        c0_rsp_mdata <= pop_mdata;
        // Forward a write landing on the popped line in this same cycle.
        if (pop_oob) begin
          c0_rsp_data <= '0;
        end else if (wr_ok && (c1_req_addr[DEPTH_LOG2-1:0] == pop_line)) begin
          c0_rsp_data <= c1_req_data;
        end else begin
          c0_rsp_data <= line_mem[pop_line];
        end
      end
      wr_valid_reg <= c1_req_valid;
      wr_mdata_reg <= c1_req_mdata;
      c1_rsp_valid <= wr_valid_reg;
      c1_rsp_mdata <= wr_mdata_reg;
      err_overflow <= err_overflow | (c0_req_valid & ~push);
      err_oob      <= err_oob | (c0_req_valid & c0_oob) | (c1_req_valid & c1_oob);
    end
  end

endmodule

// File: tb/tb_ccip_host_mem_responder.sv
// Randomized bench for ccip_host_mem_responder against a queue/array reference model.
module tb_ccip_host_mem_responder;

  localparam int ADDR_W = 42;
  localparam int LINE_W = 512;
  localparam int MDATA_W = 16;
  localparam int DEPTH_LOG2 = 6;
  localparam int FIFO_DEPTH = 8;
  localparam int ALMFULL_SLACK = 4;
  localparam int RSP_GAP = 1;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               c0_req_valid = 1'b0;
  logic [ADDR_W-1:0]  c0_req_addr = '0;
  logic [MDATA_W-1:0] c0_req_mdata = '0;
  logic               c1_req_valid = 1'b0;
  logic [ADDR_W-1:0]  c1_req_addr = '0;
  logic [MDATA_W-1:0] c1_req_mdata = '0;
  logic [LINE_W-1:0]  c1_req_data = '0;
  logic               c0TxAlmFull, c1TxAlmFull;
  logic               c0_rsp_valid, c1_rsp_valid;
  logic [MDATA_W-1:0] c0_rsp_mdata, c1_rsp_mdata;
  logic [LINE_W-1:0]  c0_rsp_data;
  logic               err_overflow, err_oob;

  ccip_host_mem_responder #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .MDATA_W(MDATA_W), .DEPTH_LOG2(DEPTH_LOG2),
    .FIFO_DEPTH(FIFO_DEPTH), .ALMFULL_SLACK(ALMFULL_SLACK), .RSP_GAP(RSP_GAP)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr), .c0_req_mdata(c0_req_mdata),
    .c1_req_valid(c1_req_valid), .c1_req_addr(c1_req_addr), .c1_req_mdata(c1_req_mdata),
    .c1_req_data(c1_req_data),
    .c0TxAlmFull(c0TxAlmFull), .c1TxAlmFull(c1TxAlmFull),
    .c0_rsp_valid(c0_rsp_valid), .c0_rsp_mdata(c0_rsp_mdata), .c0_rsp_data(c0_rsp_data),
    .c1_rsp_valid(c1_rsp_valid), .c1_rsp_mdata(c1_rsp_mdata),
    .err_overflow(err_overflow), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0]  addr;
    logic [MDATA_W-1:0] mdata;
  } rd_t;
  typedef struct {
    int                 due;
    logic [MDATA_W-1:0] mdata;
  } ack_t;

  // Reference model state
  logic [LINE_W-1:0]  m_mem [2**DEPTH_LOG2];
  rd_t                m_q[$];
  ack_t               m_acks[$];
  int                 m_gap = 0;
  int                 cyc = 0;
  logic               e_c0v = 0, e_c1v = 0, e_alm0 = 1, e_alm1 = 1, e_ovf = 0, e_oob = 0;
  logic [MDATA_W-1:0] e_c0m = '0, e_c1m = '0;
  logic [LINE_W-1:0]  e_c0d = '0;

  int tests = 0;
  int fails = 0;

  localparam logic [ADDR_W-1:0] IDLE_A = '0;
  localparam logic [LINE_W-1:0] IDLE_D = '0;

  function automatic logic [LINE_W-1:0] rnd_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic bit in_range(input logic [ADDR_W-1:0] a);
    return (a >> DEPTH_LOG2) == 0;
  endfunction

  function automatic logic [37:0] obs_ctl();
    return {c0_rsp_valid, c0_rsp_valid ? c0_rsp_mdata : 16'h0, c1_rsp_valid,
            c1_rsp_valid ? c1_rsp_mdata : 16'h0, c0TxAlmFull, c1TxAlmFull, err_overflow, err_oob};
  endfunction

  function automatic logic [37:0] exp_ctl();
    return {e_c0v, e_c0v ? e_c0m : 16'h0, e_c1v, e_c1v ? e_c1m : 16'h0, e_alm0, e_alm1, e_ovf, e_oob};
  endfunction

  // Drive one cycle of stimulus, advance the model over the edge, land on the next negedge.
  task automatic step(input bit rst_n, input bit rv, input logic [ADDR_W-1:0] ra,
                      input logic [MDATA_W-1:0] rm, input bit wv, input logic [ADDR_W-1:0] wa,
                      input logic [MDATA_W-1:0] wm, input logic [LINE_W-1:0] wd);
    bit  p;
    rd_t r;
    reset_n = rst_n;
    c0_req_valid = rv; c0_req_addr = ra; c0_req_mdata = rm;
    c1_req_valid = wv; c1_req_addr = wa; c1_req_mdata = wm; c1_req_data = wd;
    @(posedge clk);
    if (!rst_n) begin
      m_q.delete(); m_acks.delete(); m_gap = 0;
      e_c0v = 0; e_ovf = 0; e_oob = 0; e_alm0 = 1; e_alm1 = 1;
    end else begin
      p = (m_q.size() > 0) && (m_gap == 0);
      if (wv) begin
        if (in_range(wa)) m_mem[wa[DEPTH_LOG2-1:0]] = wd;
        else e_oob = 1;
        m_acks.push_back('{cyc + 2, wm});
      end
      e_c0v = p;
      if (p) begin
        r = m_q.pop_front();
        e_c0m = r.mdata;
        e_c0d = in_range(r.addr) ? m_mem[r.addr[DEPTH_LOG2-1:0]] : '0;
        m_gap = RSP_GAP;
      end else if (m_gap > 0) begin
        m_gap--;
      end
      if (rv) begin
        if (!in_range(ra)) e_oob = 1;
        if (m_q.size() < FIFO_DEPTH) m_q.push_back('{ra, rm});
        else e_ovf = 1;
      end
      e_alm0 = (m_q.size() >= FIFO_DEPTH - ALMFULL_SLACK);
      e_alm1 = 0;
    end
    cyc++;
    e_c1v = 0;
    if (m_acks.size() > 0 && m_acks[0].due == cyc) begin
      e_c1v = 1;
      e_c1m = m_acks[0].mdata;
      void'(m_acks.pop_front());
    end
    @(negedge clk);
    if (c0_rsp_valid) $display("[TB] cyc %0d c0 rsp mdata=%h data[31:0]=%h", cyc, c0_rsp_mdata, c0_rsp_data[31:0]);
    if (c1_rsp_valid) $display("[TB] cyc %0d c1 ack mdata=%h", cyc, c1_rsp_mdata);
  endtask

  task automatic idle();
    step(1, 0, IDLE_A, 16'h0, 0, IDLE_A, 16'h0, IDLE_D);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(0, 0, IDLE_A, 16'h0, 0, IDLE_A, 16'h0, IDLE_D);
    tests++;
    if ({c0TxAlmFull, c1TxAlmFull} !== 2'b11) begin
      fails++; $display("FAIL reset_almfull got %b expected 11", {c0TxAlmFull, c1TxAlmFull});
    end
    tests++;
    if ({c0_rsp_valid, c1_rsp_valid, err_overflow, err_oob, c0_rsp_mdata, c1_rsp_mdata} !== 36'h0 ||
        c0_rsp_data !== '0) begin
      fails++; $display("FAIL reset_outputs got v=%b%b err=%b%b m=%h/%h expected all zero",
                        c0_rsp_valid, c1_rsp_valid, err_overflow, err_oob, c0_rsp_mdata, c1_rsp_mdata);
    end
    for (int i = 0; i < 2; i++) begin
      idle();
      tests++;
      if (obs_ctl() !== exp_ctl()) begin
        fails++; $display("FAIL reset_release ctl cyc %0d got %h expected %h", cyc, obs_ctl(), exp_ctl());
      end
    end
  endtask

  task automatic test_fill();
    for (int a = 0; a < 2**DEPTH_LOG2 + 3; a++) begin
      if (a < 2**DEPTH_LOG2) step(1, 0, IDLE_A, 16'h0, 1, ADDR_W'(a), 16'(a + 'h100), rnd_line());
      else idle();
      tests++;
      if (obs_ctl() !== exp_ctl()) begin
        fails++; $display("FAIL fill ctl cyc %0d got %h expected %h", cyc, obs_ctl(), exp_ctl());
      end
    end
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 8; i++) begin
      if (i == 0) step(1, 0, IDLE_A, 16'h0, 1, ADDR_W'(3), 16'h11, LINE_W'(50));
      else if (i == 4) step(1, 1, ADDR_W'(3), 16'h22, 0, IDLE_A, 16'h0, IDLE_D);
      else idle();
      tests++;
      if (obs_ctl() !== exp_ctl()) begin
        fails++; $display("FAIL write_read ctl cyc %0d got %h expected %h", cyc, obs_ctl(), exp_ctl());
      end
      if (i == 1) begin
        tests++;
        if (c1_rsp_valid !== 1'b1 || c1_rsp_mdata !== 16'h11) begin
          fails++; $display("FAIL write_ack_T+2 got v=%b m=%h expected v=1 m=0011", c1_rsp_valid, c1_rsp_mdata);
        end
      end
      if (i == 5) begin
        tests++;
        if (c0_rsp_valid !== 1'b1 || c0_rsp_mdata !== 16'h22 || c0_rsp_data !== LINE_W'(50)) begin
          fails++; $display("FAIL read_T+2 got v=%b m=%h d=%h expected v=1 m=0022 d=32",
                            c0_rsp_valid, c0_rsp_mdata, c0_rsp_data[31:0]);
        end
      end
    end
  endtask

  task automatic test_burst(input int n, input string name);
    for (int i = 0; i < n + 2 * FIFO_DEPTH + 8; i++) begin
      if (i < n) step(1, 1, ADDR_W'($urandom_range(0, 2**DEPTH_LOG2 - 1)), 16'(i), 0, IDLE_A, 16'h0, IDLE_D);
      else idle();
      tests++;
      if (obs_ctl() !== exp_ctl()) begin
        fails++; $display("FAIL %s ctl cyc %0d got %h expected %h", name, cyc, obs_ctl(), exp_ctl());
      end
      if (e_c0v) begin
        tests++;
        if (c0_rsp_data !== e_c0d) begin
          fails++; $display("FAIL %s data cyc %0d got %h expected %h", name, cyc, c0_rsp_data, e_c0d);
        end
      end
    end
  endtask

  task automatic test_overflow();
    test_burst(24, "overflow");
    tests++;
    if (err_overflow !== 1'b1) begin
      fails++; $display("FAIL overflow_flag got %b expected 1", err_overflow);
    end
  endtask

  task automatic test_oob();
    logic [LINE_W-1:0] d = rnd_line();
    for (int i = 0; i < 12; i++) begin
      if (i == 0) step(1, 1, ADDR_W'('h40), 16'h33, 0, IDLE_A, 16'h0, IDLE_D);
      else if (i == 3) step(1, 0, IDLE_A, 16'h0, 1, ADDR_W'('h40), 16'h44, d);
      else if (i == 5) step(1, 1, IDLE_A, 16'h55, 0, IDLE_A, 16'h0, IDLE_D);
      else idle();
      tests++;
      if (obs_ctl() !== exp_ctl()) begin
        fails++; $display("FAIL oob ctl cyc %0d got %h expected %h", cyc, obs_ctl(), exp_ctl());
      end
      if (e_c0v) begin
        tests++;
        if (c0_rsp_data !== e_c0d) begin
          fails++; $display("FAIL oob data cyc %0d got %h expected %h", cyc, c0_rsp_data, e_c0d);
        end
      end
    end
    tests++;
    if (err_oob !== 1'b1) begin
      fails++; $display("FAIL oob_flag got %b expected 1", err_oob);
    end
  endtask

  task automatic test_same_cycle();
    for (int i = 0; i < 6; i++) begin
      if (i == 0) step(1, 1, ADDR_W'(5), 16'h66, 1, ADDR_W'(5), 16'h77, LINE_W'('hAA));
      else idle();
      tests++;
      if (obs_ctl() !== exp_ctl()) begin
        fails++; $display("FAIL same_cycle ctl cyc %0d got %h expected %h", cyc, obs_ctl(), exp_ctl());
      end
      if (i == 1) begin
        tests++;
        if (c0_rsp_valid !== 1'b1 || c0_rsp_data !== LINE_W'('hAA)) begin
          fails++; $display("FAIL same_cycle_data got v=%b d=%h expected v=1 d=aa", c0_rsp_valid, c0_rsp_data[31:0]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [63:0]        r64;
    logic [ADDR_W-1:0]  ra, wa;
    for (int i = 0; i < 430; i++) begin
      r64 = {$urandom(), $urandom()};
      ra = ($urandom_range(0, 9) == 0) ? r64[ADDR_W-1:0] : ADDR_W'($urandom_range(0, 2**DEPTH_LOG2 - 1));
      r64 = {$urandom(), $urandom()};
      wa = ($urandom_range(0, 9) == 0) ? r64[ADDR_W-1:0] : ADDR_W'($urandom_range(0, 7));
      if (i < 400) step(1, $urandom_range(0, 1) == 1, ra, 16'($urandom()),
                        $urandom_range(0, 1) == 1, wa, 16'($urandom()), rnd_line());
      else idle();
      tests++;
      if (obs_ctl() !== exp_ctl()) begin
        fails++; $display("FAIL random ctl cyc %0d got %h expected %h", cyc, obs_ctl(), exp_ctl());
      end
      if (e_c0v) begin
        tests++;
        if (c0_rsp_data !== e_c0d) begin
          fails++; $display("FAIL random data cyc %0d got %h expected %h", cyc, c0_rsp_data, e_c0d);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1, 1, ADDR_W'(10 + i), 16'(16'h80 + i), 0, IDLE_A, 16'h0, IDLE_D);
    step(0, 0, IDLE_A, 16'h0, 0, IDLE_A, 16'h0, IDLE_D);
    tests++;
    if ({c0TxAlmFull, c1TxAlmFull, c0_rsp_valid, c1_rsp_valid, err_overflow, err_oob} !== 6'b110000) begin
      fails++; $display("FAIL reset_mid_state got %b expected 110000",
                        {c0TxAlmFull, c1TxAlmFull, c0_rsp_valid, c1_rsp_valid, err_overflow, err_oob});
    end
    for (int i = 0; i < 20; i++) begin
      if (i == 12) step(1, 1, ADDR_W'(12), 16'h99, 0, IDLE_A, 16'h0, IDLE_D);
      else idle();
      tests++;
      if (obs_ctl() !== exp_ctl()) begin
        fails++; $display("FAIL reset_mid ctl cyc %0d got %h expected %h", cyc, obs_ctl(), exp_ctl());
      end
      if (e_c0v) begin
        tests++;
        if (c0_rsp_data !== e_c0d) begin
          fails++; $display("FAIL reset_mid data cyc %0d got %h expected %h", cyc, c0_rsp_data, e_c0d);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_read();
    test_burst(8, "back_to_back");
    test_overflow();
    test_oob();
    test_same_cycle();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
